stage_hold_buffer: RTL and testbench
====================================

STAGE_HOLD_BUFFER -- requirements
Module: stage_hold_buffer

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits.
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of two, >= 4.
REQ-003 clock_i  input  1  core clock; all state updates on rising edge.
REQ-004 reset_i  input  1  reset, synchronous, active-high.
REQ-005 valid_i  input  1  upstream stage presents an entry this cycle.
REQ-006 data_i  input  WIDTH  upstream payload.
REQ-007 stall_i  input  1  stall from the pipeline stall unit; when 1, hold the output register.
REQ-008 flush_i  input  1  discard all buffered and output entries.
REQ-009 valid_o  output  1  output register holds a valid entry for the downstream stage.
REQ-010 data_o  output  WIDTH  output register payload.
REQ-011 stallReq_o  output  1  stall request to the pipeline stall unit.
REQ-012 overflow_o  output  1  sticky error: push attempted while FIFO full.
REQ-013 count_o  output  log2(DEPTH)+1  current FIFO occupancy, output register excluded.

Function
REQ-014 The FIFO SHALL be circular, with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 Push: valid_i=1 and count<DEPTH writes data_i at the write pointer and increments the pointer.
REQ-016 Push while count=DEPTH drops data_i, leaves FIFO state unchanged, and sets overflow_o=1 until reset.
REQ-017 Advance: stall_i=0 loads the output register: valid_o<=(count>0), data_o<=head entry if count>0 (else data_o holds), and pops the head.
REQ-018 Hold: stall_i=1 leaves valid_o, data_o and the read pointer unchanged; pushes still proceed.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; the pushed entry is not visible as head in the same cycle.
REQ-020 Latency without bypass: valid_i at cycle N, empty FIFO, stall_i=0 gives valid_o=1 with that data at cycle N+2.
REQ-021 stallReq_o SHALL be combinational from count: 1 when count>=DEPTH-2, else 0. This leaves 2 entries of headroom for the stall unit's registered one-cycle response.
REQ-022 Entries SHALL leave in strict arrival order; no entry duplicated or lost except under REQ-016 or flush.
REQ-023 flush_i=1 SHALL zero count and both pointers and set valid_o<=0, overriding push, pop and hold in that cycle; overflow_o is unaffected.
REQ-024 count_o SHALL equal the number of valid FIFO entries after every edge.

Reset
REQ-025 reset_i=1 at an edge SHALL set valid_o=0, data_o=0, overflow_o=0, count=0 and both pointers to 0.
REQ-026 Reset SHALL override flush_i, valid_i and stall_i; entries in flight mid-operation are discarded.
REQ-027 After reset, stallReq_o=0.

Configuration
REQ-028 Macro STAGE_HOLD_BUFFER_BYPASS_EN, when defined: valid_i=1, count=0, stall_i=0 and flush_i=0 loads data_i directly into the output register (valid_o<=1), does not write it to the FIFO, and gives 1-cycle latency.
REQ-029 With STAGE_HOLD_BUFFER_BYPASS_EN undefined, all entries pass through the FIFO and REQ-020 latency applies.

Verification
REQ-030 Reset, then valid_i=1 with data 0xA5A5_0001 for one cycle, stall_i=0 -> valid_o=1, data_o=0xA5A5_0001 at +2 cycles (+1 with bypass), then valid_o=0.
REQ-031 stall_i=1, push 0x11, 0x22, 0x33 on consecutive cycles -> count_o=1,2,3; stallReq_o rises when count_o=2; valid_o unchanged.
REQ-032 With DEPTH=4 full and stall_i=1, push 0x44 -> count_o stays 4, overflow_o=1 and stays 1; release stall -> 0x11,0x22,0x33,0x... emerge in order.
REQ-033 count_o=3 with pointers wrapped past 3, push and pop every cycle for 8 cycles -> count_o constant 3, output sequence matches input order.
REQ-034 count_o=3, valid_o=1, assert flush_i with valid_i=1 -> next cycle count_o=0, valid_o=0, stallReq_o=0, overflow_o unchanged.
REQ-035 Assert reset_i mid-stream with count_o=2 -> next cycle all outputs are at reset values and no stale entry appears afterwards.

Source files
------------

// File: rtl/stage_hold_buffer_if.sv
// Handshake/payload bundle between an upstream stage, the stage hold buffer and the stall unit.
// The slave modport is the buffer side; the master modport drives the buffer's inputs.
interface stage_hold_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             stall_i;
    logic             flush_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             stallReq_o;
    logic             overflow_o;
    logic [CW-1:0]    count_o;

    modport master (
        output valid_i, data_i, stall_i, flush_i,
        input  valid_o, data_o, stallReq_o, overflow_o, count_o
    );

    modport slave (
        input  valid_i, data_i, stall_i, flush_i,
        output valid_o, data_o, stallReq_o, overflow_o, count_o
    );
endinterface

// File: rtl/stage_hold_buffer.sv
// Circular FIFO feeding a stallable output register, with sticky overflow and early stall request.
// Define STAGE_HOLD_BUFFER_BYPASS_EN to let an entry skip an empty FIFO (1-cycle latency).
module stage_hold_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    stage_hold_buffer_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overflow_q, overflow_d;

    logic full, empty, bypass_en, push_en, pop_en;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
`ifdef STAGE_HOLD_BUFFER_BYPASS_EN
        bypass_en = bus.valid_i && empty && !bus.stall_i && !bus.flush_i;
`else
        bypass_en = 1'b0;
`endif
        // A bypassed entry goes straight to the output register, never into the FIFO.
        push_en = bus.valid_i && !full && !bypass_en && !bus.flush_i;
        pop_en  = !bus.stall_i && !empty && !bus.flush_i;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        data_d     = data_q;
        overflow_d = overflow_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_en) - CW'(pop_en);
            if (!bus.stall_i) begin
                valid_d = !empty || bypass_en;
                if (bypass_en) begin
                    data_d = bus.data_i;
                end else if (!empty) begin
                    data_d = mem_q[rd_ptr_q];
                end
            end
            if (bus.valid_i && full) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clock_i) begin
        if (push_en && !reset_i) begin
            mem_q[wr_ptr_q] <= bus.data_i;
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.data_o     = data_q;
    assign bus.overflow_o = overflow_q;
    assign bus.count_o    = count_q;
    // Two entries of headroom cover the stall unit's registered response.
    assign bus.stallReq_o = (count_q >= CW'(DEPTH - 2));
endmodule

// File: tb/tb_stage_hold_buffer.sv
// Scoreboard bench for stage_hold_buffer: directed scenarios followed by randomized traffic,
// checked against a queue-based reference model.
module tb_stage_hold_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clock_i = 1'b0;
    logic reset_i;
    always #5 clock_i = ~clock_i;

    stage_hold_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stage_hold_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    // Reference model: FIFO contents, output register state, sticky overflow.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    bit               m_valid = 1'b0;
    bit               m_ovf   = 1'b0;

    int  errors  = 0;
    int  checks  = 0;
    bit  started = 1'b0;
    bit  s_load  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [WIDTH-1:0] d, input bit s,
                              input bit f, input bit r);
        int old_size;
        if (r) begin
            mq.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end else if (f) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            old_size = mq.size();
`ifdef STAGE_HOLD_BUFFER_BYPASS_EN
            if (v && old_size == 0 && !s) begin
                m_valid = 1'b1;
                exp_q.push_back(d);
                return;
            end
`endif
            if (!s) begin
                if (old_size > 0) begin
                    m_valid = 1'b1;
                    exp_q.push_back(mq.pop_front());
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (v) begin
                if (old_size < DEPTH) mq.push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit s,
                        input bit f, input bit r);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.stall_i = s;
        bus.flush_i = f;
        reset_i     = r;
        @(posedge clock_i);
        model_edge(v, d, s, f, r);
        #1;
    endtask

    always @(posedge clock_i) s_load <= !bus.stall_i && !bus.flush_i && !reset_i;

    // Monitor: state checks every cycle; payload popped from the scoreboard on each new output.
    always @(negedge clock_i) begin
        if (started) begin
            chk("count", 64'(bus.count_o), 64'(mq.size()));
            chk("stallReq", 64'(bus.stallReq_o), 64'(mq.size() >= DEPTH - 2));
            chk("overflow", 64'(bus.overflow_o), 64'(m_ovf));
            chk("valid", 64'(bus.valid_o), 64'(m_valid));
            if (s_load && bus.valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(bus.data_o), 64'hDEAD_0000_0000_0000);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    $display("out data=%08h exp=%08h count=%0d", bus.data_o, e, bus.count_o);
                    chk("data", 64'(bus.data_o), 64'(e));
                end
            end
        end
    end

    initial begin
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        reset_i     = 1'b1;

        step(0, '0, 0, 0, 1);
        started = 1'b1;
        step(0, '0, 0, 0, 1);
        chk("reset_data", 64'(bus.data_o), 64'h0);

        // Single entry end-to-end latency.
        step(1, 32'hA5A5_0001, 0, 0, 0);
        repeat (3) step(0, '0, 0, 0, 0);

        // Fill under stall, then overflow on a full FIFO.
        step(1, 32'h11, 1, 0, 0);
        step(1, 32'h22, 1, 0, 0);
        step(1, 32'h33, 1, 0, 0);
        step(1, 32'h44, 1, 0, 0);
        step(1, 32'h55, 1, 0, 0);
        step(0, '0, 1, 0, 0);
        repeat (6) step(0, '0, 0, 0, 0);

        // Occupancy 3 with wrapped pointers, then push and pop together.
        step(1, 32'h101, 1, 0, 0);
        step(1, 32'h102, 1, 0, 0);
        step(1, 32'h103, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h200 + 32'(i), 0, 0, 0);

        // Flush with a valid output and a push in the same cycle.
        step(1, 32'h301, 0, 1, 0);
        step(0, '0, 0, 0, 0);

        // Reset while entries are buffered.
        step(1, 32'h401, 1, 0, 0);
        step(1, 32'h402, 1, 0, 0);
        step(1, 32'h403, 0, 0, 1);
        chk("reset_mid_data", 64'(bus.data_o), 64'h0);
        repeat (4) step(0, '0, 0, 0, 0);

        // Randomized traffic with varying stall pressure.
        for (int ph = 0; ph < 8; ph++) begin
            int stall_pct;
            stall_pct = (ph % 4) * 25 + 10;
            for (int i = 0; i < 250; i++) begin
                bit v, s, f, r;
                v = ($urandom_range(99) < 70);
                s = ($urandom_range(99) < stall_pct);
                f = ($urandom_range(99) < 2);
                r = ($urandom_range(499) == 0);
                step(v, $urandom, s, f, r);
            end
        end

        repeat (8) step(0, '0, 0, 0, 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
